uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ requesters using round-robin arbitration.
- Serialises the granted byte as 8N1: start bit, 8 data bits LSB first, stop bit.
- Bit timing comes from baud_tick, a one-clk-cycle enable pulse from the baud generator, issued once per bit period.
- Sits between packet sources (status, debug, response engines) and the UART pin.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- DATA_WIDTH, 8, bits per character.
- GRANT_W, $clog2(NUM_REQ), width of grant_id; derived, not overridden.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset (system resets when reset_n=0).
- baud_tick  input  1  one-cycle pulse per bit period, synchronous to clk.
- req_valid  input  NUM_REQ  requester i has a byte pending.
- req_data  input  NUM_REQ*DATA_WIDTH  byte for requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot accept strobe; byte i is taken on the edge where req_valid[i] and req_ready[i] are both high.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- grant_id  output  GRANT_W  index of the requester owning the current frame.

Behaviour:
- Reset (async): state=IDLE, tx_out=1, tx_busy=0, grant_id=0, req_ready=0, bit counter=0, shift register=0. Last-grant pointer=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, WAIT, START, DATA, STOP. All transitions other than IDLE->WAIT happen only on clk edges where baud_tick=1.
- IDLE:
  - tx_out=1, tx_busy=0.
  - If any req_valid: pick the first valid index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready is combinational: exactly that one bit is high in the same cycle.
  - On the edge: latch the byte, set grant_id and last_grant, go to WAIT.
- WAIT: tx_out=1; on tick go to START. This aligns the start bit to a tick.
- START: tx_out=0; on tick go to DATA, bit counter=0.
- DATA:
  - tx_out = shift[0].
  - On tick: shift right and increment the counter.
  - After the tick that ends bit DATA_WIDTH-1, go to STOP.
- STOP: tx_out=1. On tick:
  - If any req_valid: arbitrate as in IDLE (req_ready combinational, this cycle only) and go directly to START. No idle bit between frames.
  - Otherwise go to IDLE.
- tx_busy=1 in WAIT, START, DATA and STOP.
- grant_id holds its value until the next grant.
- req_ready is 0 in every state and cycle not listed above.
- Requesters hold req_valid and req_data stable until accepted. Dropping req_valid before accept is legal; that requester is simply not considered.
- Changes to req_data after the accept edge do not affect the frame in flight.
- baud_tick arriving in the same cycle as an IDLE accept is ignored; WAIT consumes the next tick.
- tx_out is registered; no glitches.
- Each frame occupies exactly 10 bit periods from START to the end of STOP (11 with parity), plus 0-1 bit period in WAIT when starting from IDLE.
- Reset asserted mid-frame: tx_out returns to 1 immediately and the frame is abandoned. No req_ready is reissued for the abandoned byte.

Optional Feature:
- Macro: UART_ARB_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_out = XOR of the latched DATA_WIDTH bits (even parity) for one bit period.
  - Frame becomes 11 bit periods.
- Undefined: no PARITY state; 8N1 framing exactly as above.

Test Plan:
- Single request: reset, baud_tick every 16 clks, req_valid=4'b0001, req_data[7:0]=8'hA5 -> req_ready[0] pulses 1 cycle. After the next tick, tx_out sequence per bit period is 0,1,0,1,0,0,1,0,1,1. tx_busy falls in the cycle after the stop-bit-ending tick.
- Round-robin: all four valid continuously with distinct bytes 8'h10..8'h13 -> grant order 0,1,2,3,0. Frames are back-to-back with no idle bit; grant_id matches each frame.
- Fairness after skip: only requesters 1 and 3 valid, last_grant=1 -> next grant is 3, then 1.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 -> tx_out=1 and tx_busy=0 asynchronously. After release, req_valid=4'b0110 grants requester 1 first.
- Late tick / data change: req_data changes to 8'hFF one cycle after accept -> transmitted byte is the originally latched value. A tick coincident with the accept cycle does not shorten the WAIT period.
- Parity (UART_ARB_PARITY_EN): byte 8'h07 -> parity bit 1 after data bit 7; byte 8'h03 -> parity bit 0; frame is 11 bit periods.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one serial tx line (start, DATA_WIDTH bits LSB first, stop); UART_ARB_PARITY_EN adds even parity.
// Latency: byte accepted on the request cycle from IDLE, start bit on the next baud_tick; back-to-back frames have no idle bit.
// Backpressure: req_ready is a one-cycle strobe, only in IDLE or on the tick ending STOP; otherwise requesters hold.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_tick,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [GRANT_W-1:0]            grant_id
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_ARB_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GRANT_W-1:0]     last_q, grant_q, pick, idx_g;
  logic [DATA_WIDTH-1:0]  pick_data;
  logic                   tx_q, tx_d;
  logic                   found, arb_en, accept;
`ifdef UART_ARB_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx_g = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_g = GRANT_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx_g]) begin
        found = 1'b1;
        pick  = idx_g;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GRANT_W'(i)) pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign arb_en = (state_q == S_IDLE) || ((state_q == S_STOP) && baud_tick);
  assign accept = arb_en && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = 1'b1;
`ifdef UART_ARB_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE:  if (found) state_d = S_WAIT;
      S_WAIT:  if (baud_tick) state_d = S_START;
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef UART_ARB_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_ARB_PARITY_EN
      S_PARITY: if (baud_tick) state_d = S_STOP;
`endif
      S_STOP: begin
        if (baud_tick) state_d = found ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      shift_d = pick_data;
`ifdef UART_ARB_PARITY_EN
      par_d   = ^pick_data;
`endif
    end

    // Line level is decoded from the next state so tx_out comes straight from a flop.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_ARB_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_REQ - 1);
`ifdef UART_ARB_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
`ifdef UART_ARB_PARITY_EN
      par_q   <= par_d;
`endif
      if (accept) begin
        grant_q <= pick;
        last_q  <= pick;
      end
    end
  end

  assign tx_out   = tx_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, a round-robin reference model and a tick-sampling line decoder.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DW       = 8;
  localparam int TICK_DIV = 16;
`ifdef UART_ARB_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic                   clk;
  logic                   reset_n;
  logic                   baud_tick;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   tx_out;
  logic                   tx_busy;
  logic [1:0]             grant_id;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_out(tx_out), .tx_busy(tx_busy), .grant_id(grant_id)
  );

  typedef struct { int id; logic [7:0] dat; } exp_t;
  typedef struct { int gid; logic [15:0] bits; int gap; logic busy; } rx_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] src_q[NUM_REQ][$];
  exp_t       exp_q[$];
  rx_t        rx_q[$];
  int         ord_q[$];
  int         model_last;
  int         acc_cnt;
  logic       acc_tick;
  int         rx_n;
  int         tick_phase;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick  = 1'b0;
    tick_phase = 0;
    forever begin
      @(posedge clk); #1;
      tick_phase = (tick_phase + 1) % TICK_DIV;
      baud_tick  = (tick_phase == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
`ifdef UART_ARB_PARITY_EN
    b[9]  = ^d;
    b[10] = 1'b1;
`else
    b[9]  = 1'b1;
`endif
    return b;
  endfunction

  // Requesters: each presents the head of its queue; after acceptance the slot shows 8'hFF until refilled.
  initial begin
    logic [NUM_REQ-1:0] acc_mask;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc_mask = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i]) begin
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
          req_data[i*DW +: DW] = 8'hFF;
        end
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Reference arbitration and line decoder.
  initial begin
    int         p;
    int         idle_ticks;
    int         rx_gid;
    int         rx_gap;
    logic [15:0] rx_bits;
    exp_t       e;
    rx_t        f;
    rx_n = 0; idle_ticks = 0; acc_cnt = 0; acc_tick = 1'b0;
    model_last = NUM_REQ - 1;
    rx_gid = 0; rx_gap = 0; rx_bits = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rx_n = 0; idle_ticks = 0; model_last = NUM_REQ - 1;
      end else begin
        if (req_ready != '0) begin
          p = rr_pick(req_valid, model_last);
          chk("req_ready_grant", req_ready, (p < 0) ? 0 : (1 << p));
          if (p >= 0) begin
            model_last = p;
            acc_cnt++;
            acc_tick = baud_tick;
            e.id  = p;
            e.dat = req_data[p*DW +: DW];
            exp_q.push_back(e);
          end
        end
        if (baud_tick) begin
          if (rx_n == 0) begin
            if (tx_out == 1'b0) begin
              rx_n = 1; rx_bits = '0; rx_gid = int'(grant_id); rx_gap = idle_ticks;
            end else begin
              idle_ticks++;
            end
          end else begin
            rx_bits[rx_n] = tx_out;
            rx_n++;
            if (rx_n == FRAME_BITS) begin
              f.gid = rx_gid; f.bits = rx_bits; f.gap = rx_gap; f.busy = tx_busy;
              rx_q.push_back(f);
              rx_n = 0; idle_ticks = 0;
            end
          end
        end
      end
    end
  end

  task automatic nstep();
    @(negedge clk); #1;
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (rx_q.size() < n && c < 250 * (n + 1)) begin
      nstep();
      c++;
    end
    chk("frame_timeout", rx_q.size() >= n, 1);
  endtask

  task automatic cmp_frames(input string tag, input bit b2b);
    rx_t  r;
    exp_t e;
    int   k;
    k = 0;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      ord_q.push_back(r.gid);
      chk({tag, "_grant_id"}, r.gid, e.id);
      chk({tag, "_bits"}, r.bits, frame_bits(e.dat));
      chk({tag, "_busy_at_stop"}, r.busy, 1);
      if (b2b && k > 0) chk({tag, "_gap"}, r.gap, 0);
      k++;
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    reset_n = 1'b0;
    repeat (3) nstep();
    rx_q.delete(); exp_q.delete(); ord_q.delete();
    reset_n = 1'b1;
    repeat (2) nstep();
  endtask

  initial begin
    int         n;
    int         c;
    int         cnt;
    int         a0;
    int         rr_exp[5];
    logic [7:0] b;
    rx_t        r;
    rr_exp = '{0, 1, 2, 3, 0};

    reset_n = 1'b0;
    repeat (3) nstep();
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    reset_n = 1'b1;
    repeat (4) nstep();

    // Single request, fixed byte.
    src_q[0].push_back(8'hA5);
    wait_frames(1);
    if (rx_q.size() > 0) begin
      r = rx_q[0];
      chk("a5_line_bits", r.bits[8:0], 9'h14A);
    end
    cmp_frames("single", 1'b0);
    nstep();
    chk("busy_fall", tx_busy, 0);
    chk("single_accepts", acc_cnt, 1);

    // Round robin, all four requesters continuously valid.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_REQ; i++)
        src_q[i].push_back((k == 0) ? 8'(8'h10 + i) : 8'($urandom));
    wait_frames(8);
    cmp_frames("rr", 1'b1);
    chk("rr_count", ord_q.size(), 8);
    for (int k = 0; k < 5 && k < ord_q.size(); k++) chk("rr_order", ord_q[k], rr_exp[k]);

    // Fairness after skipping idle requesters.
    src_q[1].push_back(8'($urandom));
    wait_frames(1);
    cmp_frames("fair_pre", 1'b0);
    ord_q.delete();
    src_q[1].push_back(8'($urandom));
    src_q[3].push_back(8'($urandom));
    wait_frames(2);
    cmp_frames("fair", 1'b1);
    chk("fair_n", ord_q.size(), 2);
    if (ord_q.size() >= 2) begin
      chk("fair_first", ord_q[0], 3);
      chk("fair_second", ord_q[1], 1);
    end

    // Accept coincident with a tick; data changes right after accept.
    c = 0;
    while (tick_phase != TICK_DIV - 1 && c < 3 * TICK_DIV) begin nstep(); c++; end
    b  = 8'($urandom_range(0, 254));
    a0 = acc_cnt;
    src_q[0].push_back(b);
    c = 0;
    while (acc_cnt == a0 && c < 10) begin nstep(); c++; end
    chk("tick_coincident", acc_tick, 1);
    n = 0;
    while (tx_out !== 1'b0 && n < 100) begin nstep(); n++; end
    chk("wait_len", n, TICK_DIV + 1);
    wait_frames(1);
    cmp_frames("late_tick", 1'b0);

    // Reset during data bit 3.
    ord_q.delete();
    b = 8'($urandom) & 8'hF7;
    src_q[2].push_back(b);
    c = 0;
    while (rx_n != 4 && c < 400) begin nstep(); c++; end
    repeat (5) nstep();
    chk("pre_reset_bit3", tx_out, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_out", tx_out, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    repeat (3) nstep();
    rx_q.delete(); exp_q.delete();
    reset_n = 1'b1;
    nstep();
    src_q[1].push_back(8'($urandom));
    src_q[2].push_back(8'($urandom));
    wait_frames(2);
    cmp_frames("post_rst", 1'b1);
    if (ord_q.size() >= 2) begin
      chk("post_rst_first", ord_q[0], 1);
      chk("post_rst_second", ord_q[1], 2);
    end

    // Randomised request mixes.
    for (int rnd = 0; rnd < 6; rnd++) begin
      cnt = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        n = (i == rnd % NUM_REQ) ? $urandom_range(1, 2) : $urandom_range(0, 2);
        for (int j = 0; j < n; j++) src_q[i].push_back(8'($urandom));
        cnt += n;
      end
      wait_frames(cnt);
      cmp_frames("rand", 1'b1);
    end

`ifdef UART_ARB_PARITY_EN
    src_q[0].push_back(8'h07);
    wait_frames(1);
    if (rx_q.size() > 0) begin r = rx_q[0]; chk("parity_07", r.bits[9], 1); end
    cmp_frames("par07", 1'b0);
    src_q[0].push_back(8'h03);
    wait_frames(1);
    if (rx_q.size() > 0) begin r = rx_q[0]; chk("parity_03", r.bits[9], 0); end
    cmp_frames("par03", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
